// File: rtl/img2col_window_ctrl_if.sv
// img2col_window_ctrl_if
// Bundles the frame-control, column-stream and window-stream signals of
// img2col_window_ctrl.
//   start/stride/n_rows : frame control (stride, n_rows latched on start)
//   col_in/col_valid/col_ready : column stream, K pixels per column
//   win_out/win_valid/win_ready : window stream, KxK pixels per window
//   busy/done : status
// Modports: master = column producer / window consumer, slave = the block.
interface img2col_window_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int K      = 5
);
  logic                    start;
  logic [2:0]              stride;
  logic [7:0]              n_rows;
  logic [K*DATA_W-1:0]     col_in;
  logic                    col_valid;
  logic                    col_ready;
  logic [K*K*DATA_W-1:0]   win_out;
  logic                    win_valid;
  logic                    win_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start, stride, n_rows, col_in, col_valid, win_ready,
    input  col_ready, win_out, win_valid, busy, done
  );

  modport slave (
    input  start, stride, n_rows, col_in, col_valid, win_ready,
    output col_ready, win_out, win_valid, busy, done
  );
endinterface

// File: rtl/img2col_window_ctrl.sv
// img2col_window_ctrl
// Builds KxK sliding windows from a stream of K-pixel image columns.
// Each row consumes IMG_W columns: K to fill, then `stride` per further
// window; columns left over after the last window are drained.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : img2col_window_ctrl_if.slave (frame control, column in,
//          window out, busy/done)
module img2col_window_ctrl #(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int IMG_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  img2col_window_ctrl_if.slave    bus
);

  // Consumed-column counter is wide enough to hold consumed+stride.
  localparam int CW = $clog2(IMG_W + 8) + 1;
  localparam int KW = $clog2(K + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SHIFT, S_EMIT, S_DRAIN, S_DONE
  } state_t;

  state_t                                  r_state;
  logic [2:0]                              r_stride;
  logic [7:0]                              r_nrows;
  logic [7:0]                              r_row;
  logic [CW-1:0]                           r_cons;
  logic [KW-1:0]                           r_cnt;
  logic                                    r_col_ready;
  logic                                    r_win_valid;
  logic                                    r_busy;
  logic                                    r_done;
  logic [K-1:0][K-1:0][DATA_W-1:0]         r_win;   // [row][col]

  logic                                    w_col_xfer;
  logic                                    w_shift;
  logic [2:0]                              w_stride_eff;
  logic [CW-1:0]                           w_next_cons;
  logic [KW-1:0]                           w_cnt_last;
  logic                                    w_row_last;

  assign w_col_xfer   = bus.col_valid & r_col_ready;
  // DRAIN accepts columns but does not load them into the window.
  assign w_shift      = w_col_xfer & ((r_state == S_FILL) | (r_state == S_SHIFT));
  assign w_stride_eff = (bus.stride == 3'd0 || int'(bus.stride) > K) ? 3'd1 : bus.stride;
  assign w_next_cons  = r_cons + CW'(r_stride);
  assign w_cnt_last   = (r_state == S_FILL) ? KW'(K - 1) : KW'(r_stride - 3'd1);
  assign w_row_last   = (r_row == r_nrows - 8'd1);

  assign bus.col_ready = r_col_ready;
  assign bus.win_valid = r_win_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.win_out   = r_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
    end else if (w_shift) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][K-1] <= bus.col_in[r*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stride    <= 3'd0;
      r_nrows     <= 8'd0;
      r_row       <= 8'd0;
      r_cons      <= '0;
      r_cnt       <= '0;
      r_col_ready <= 1'b0;
      r_win_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_stride    <= w_stride_eff;
          r_nrows     <= (bus.n_rows == 8'd0) ? 8'd1 : bus.n_rows;
          r_row       <= 8'd0;
          r_cons      <= '0;
          r_cnt       <= '0;
          r_col_ready <= 1'b1;
          r_busy      <= 1'b1;
          r_state     <= S_FILL;
        end
        S_FILL, S_SHIFT: if (w_col_xfer) begin
          r_cons <= r_cons + 1'b1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == w_cnt_last) begin
            r_col_ready <= 1'b0;
            r_win_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: if (bus.win_ready) begin
          r_win_valid <= 1'b0;
          if (w_next_cons <= CW'(IMG_W)) begin
            r_cnt       <= '0;
            r_col_ready <= 1'b1;
            r_state     <= S_SHIFT;
          end else if (r_cons < CW'(IMG_W)) begin
            r_col_ready <= 1'b1;
            r_state     <= S_DRAIN;
          end else if (w_row_last) begin
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_row       <= r_row + 8'd1;
            r_cons      <= '0;
            r_cnt       <= '0;
            r_col_ready <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        S_DRAIN: if (w_col_xfer) begin
          r_cons <= r_cons + 1'b1;
          if (r_cons == CW'(IMG_W - 1)) begin
            if (w_row_last) begin
              r_col_ready <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_row   <= r_row + 8'd1;
              r_cons  <= '0;
              r_cnt   <= '0;
              r_state <= S_FILL;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
